// File: rtl/iob_native_arb_pkg.sv
// Shared definitions for the native-interface two-master arbiter.
package iob_native_arb_pkg;

    // Arbiter state encodings
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_BUSY0 = 2'd1;
    localparam logic [1:0] ARB_BUSY1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ARB_IDLE,
        BUSY0 = ARB_BUSY0,
        BUSY1 = ARB_BUSY1
    } arb_state_t;

    // Byte-strobe width for a given data width
    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_arb2_rr.sv
// Two-request grant selection with last-grant tracking.
// IOB_NATIVE_ARB2_FIXED_PRIO_EN: m0 always preferred, no last-grant state.
module iob_arb2_rr (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic done,
    input  logic done_id,
    output logic pick_c,
    output logic hand_to_m1_c
);

`ifdef IOB_NATIVE_ARB2_FIXED_PRIO_EN

    // Clock, reset and completion tracking have no role under fixed priority
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, req1, done, done_id};

    // m0 always wins; a finished m0 never hands directly to m1
    always_comb begin
        pick_c       = ~req0;
        hand_to_m1_c = 1'b0;
    end

`else

    logic last_grant;

    // Remember which master finished last; reset favours m0 on the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (done) begin
            last_grant <= done_id;
        end
    end

    // Single requester wins outright; a tie goes to the master not served last
    always_comb begin
        pick_c       = 1'b0;
        hand_to_m1_c = 1'b1;
        if (req0 && req1) begin
            pick_c = ~last_grant;
        end else if (req1) begin
            pick_c = 1'b1;
        end
    end

`endif

endmodule

// File: rtl/iob_native_arb2.sv
// Two-master to one-slave arbiter for the native valid/ready memory interface.
// Grant is held for a whole transaction; no added latency once granted.
// Build option: IOB_NATIVE_ARB2_FIXED_PRIO_EN (fixed priority, see iob_arb2_rr).
module iob_native_arb2
    import iob_native_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        m0_valid,
    input  logic [ADDR_W-1:0]           m0_addr,
    input  logic [DATA_W-1:0]           m0_wdata,
    input  logic [strb_w(DATA_W)-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]           m0_rdata,
    output logic                        m0_ready,

    input  logic                        m1_valid,
    input  logic [ADDR_W-1:0]           m1_addr,
    input  logic [DATA_W-1:0]           m1_wdata,
    input  logic [strb_w(DATA_W)-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]           m1_rdata,
    output logic                        m1_ready,

    output logic                        s_valid,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [strb_w(DATA_W)-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]           s_rdata,
    input  logic                        s_ready
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic pick;
    logic hand_to_m1;
    logic arb_done;
    logic done_id;

    iob_arb2_rr u_rr (
        .clk          (clk),
        .rst          (rst),
        .req0         (m0_valid),
        .req1         (m1_valid),
        .done         (arb_done),
        .done_id      (done_id),
        .pick_c       (pick),
        .hand_to_m1_c (hand_to_m1)
    );

    // Read data is shared; each master qualifies it with its own ready
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    // State register; reset abandons any in-flight slave access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slave-side mux and ready steering
    always_comb begin
        state_d  = state_q;
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        arb_done = 1'b0;
        done_id  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = pick ? BUSY1 : BUSY0;
                end
            end

            BUSY0: begin
                s_valid  = m0_valid;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
                if (s_ready) begin
                    arb_done = 1'b1;
                    done_id  = 1'b0;
                    state_d  = (m1_valid && hand_to_m1) ? BUSY1 : IDLE;
                end
            end

            BUSY1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
                if (s_ready) begin
                    arb_done = 1'b1;
                    done_id  = 1'b1;
                    state_d  = m0_valid ? BUSY0 : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
